// File: rtl/alu_sequencer_if.sv
// Request, ALU-drive and response signals of alu_sequencer grouped into one bundle.
// The slave modport is the sequencer's view; master is the control unit / ALU / consumer side.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  alu_opcode;
  logic        alu_exec;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] alu_hi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_hi, rsp_ready,
    output req_ready, alu_opcode, alu_exec, alu_a, alu_b,
           rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_hi, rsp_ready,
    input  req_ready, alu_opcode, alu_exec, alu_a, alu_b,
           rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU issue/capture controller with per-opcode settle windows.
// Optional ALU_SEQ_DIV0_TRAP_EN: DIV by zero is trapped without exec and flagged on rsp_err.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready high
// S_EXEC | alu_exec high, counter running down to the capture edge
// S_RESP | response held until rsp_ready
module alu_sequencer #(
  parameter int ALU_WAIT    = 1,
  parameter int MULDIV_WAIT = 4
) (
  input  logic          clock,
  input  logic          clear_n,
  alu_sequencer_if.slave bus
);

  localparam int MAX_WAIT = (ALU_WAIT > MULDIV_WAIT) ? ALU_WAIT : MULDIV_WAIT;
  localparam int CW       = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] ALU_LOAD    = CW'(ALU_WAIT - 1);
  localparam logic [CW-1:0] MULDIV_LOAD = CW'(MULDIV_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_op, w_op_nxt;
  logic [31:0]     r_a, w_a_nxt;
  logic [31:0]     r_b, w_b_nxt;
  logic [31:0]     r_lo, w_lo_nxt;
  logic [31:0]     r_hi, w_hi_nxt;
  logic            r_err, w_err_nxt;

  logic w_muldiv_req;
  logic w_muldiv_cur;
  logic w_undef_req;
  logic w_trap_req;

  assign w_muldiv_req = (bus.req_op == 4'd11) || (bus.req_op == 4'd12);
  assign w_muldiv_cur = (r_op == 4'd11) || (r_op == 4'd12);
  assign w_undef_req  = (bus.req_op >= 4'd13);

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign w_trap_req = (bus.req_op == 4'd12) && (bus.req_b == 32'd0);
`else
  assign w_trap_req = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_op_nxt = bus.req_op;
          w_a_nxt  = bus.req_a;
          w_b_nxt  = bus.req_b;
          // Undefined opcodes and trapped divides skip the ALU entirely.
          if (w_undef_req || w_trap_req) begin
            w_state_nxt = S_RESP;
            w_lo_nxt    = 32'd0;
            w_hi_nxt    = w_trap_req ? bus.req_a : 32'd0;
            w_err_nxt   = w_trap_req;
          end else begin
            w_state_nxt = S_EXEC;
            w_cnt_nxt   = w_muldiv_req ? MULDIV_LOAD : ALU_LOAD;
          end
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_lo_nxt    = bus.alu_result;
          w_hi_nxt    = w_muldiv_cur ? bus.alu_hi : 32'd0;
          w_err_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.alu_exec   = (r_state == S_EXEC);
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.alu_opcode = r_op;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.rsp_lo     = r_lo;
  assign bus.rsp_hi     = r_hi;
  assign bus.rsp_err    = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level timeline model plus directed vectors.
// Honours ALU_SEQ_DIV0_TRAP_EN so the same bench covers both builds.
module tb_alu_sequencer;

  localparam int ALU_W = 1;
  localparam int MD_W  = 4;
`ifdef ALU_SEQ_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear_n = 1'b1;
  always #5 clock = ~clock;

  alu_sequencer_if bus ();

  alu_sequencer #(.ALU_WAIT(ALU_W), .MULDIV_WAIT(MD_W)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: {hi, lo}. Non-MUL/DIV ops drive junk on hi that must be dropped.
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'd0:    alu_fn = {32'h1234_5678, a + b};
      4'd1:    alu_fn = {32'h1234_5678, a - b};
      4'd2:    alu_fn = {32'h1234_5678, a & b};
      4'd3:    alu_fn = {32'h1234_5678, a | b};
      4'd4:    alu_fn = {32'h1234_5678, a ^ b};
      4'd11: begin
        p = {32'd0, a} * {32'd0, b};
        alu_fn = p;
      end
      4'd12:   alu_fn = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: alu_fn = {32'h1234_5678, a + b + {28'd0, op}};
    endcase
  endfunction

  // ALU outputs are only meaningful while exec is high; garbage otherwise.
  assign {bus.alu_hi, bus.alu_result} = bus.alu_exec ? alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b)
                                                     : 64'hBAD0_0BAD_DEAD_BEEF;

  // Timeline model: one outstanding transaction, accepted at cycle m_tacc, exec for m_n cycles, then response.
  bit          m_active = 1'b0;
  bit          acc_evt  = 1'b0;
  int          cyc      = 0;
  int          m_tacc   = 0;
  int          m_n      = 0;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_lo, m_hi;
  logic        m_err;

  always @(posedge clock or negedge clear_n) begin
    logic [63:0] r;
    if (!clear_n) begin
      m_active = 1'b0;
      acc_evt  = 1'b0;
    end else begin
      acc_evt = 1'b0;
      if (m_active) begin
        if ((cyc - m_tacc + 1) > m_n && bus.rsp_ready) m_active = 1'b0;
        cyc++;
      end else begin
        cyc++;
        if (bus.req_valid) begin
          m_active = 1'b1;
          acc_evt  = 1'b1;
          m_tacc   = cyc;
          m_op     = bus.req_op;
          m_a      = bus.req_a;
          m_b      = bus.req_b;
          r        = alu_fn(bus.req_op, bus.req_a, bus.req_b);
          if (bus.req_op >= 4'd13) begin
            m_n = 0; m_lo = 32'd0; m_hi = 32'd0; m_err = 1'b0;
          end else if (TRAP && bus.req_op == 4'd12 && bus.req_b == 32'd0) begin
            m_n = 0; m_lo = 32'd0; m_hi = bus.req_a; m_err = 1'b1;
          end else if (bus.req_op == 4'd11 || bus.req_op == 4'd12) begin
            m_n = MD_W; m_lo = r[31:0]; m_hi = r[63:32]; m_err = 1'b0;
          end else begin
            m_n = ALU_W; m_lo = r[31:0]; m_hi = 32'd0; m_err = 1'b0;
          end
        end
      end
    end
  end

  int k_cmp;
  always @(negedge clock) begin
    if (!clear_n) begin
      chk("rst_ctl", {bus.req_ready, bus.alu_exec, bus.rsp_valid, bus.busy}, 4'b1000);
      chk("rst_data", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_lo, bus.rsp_hi, bus.rsp_err}, '0);
    end else if (!m_active) begin
      chk("idle_ctl", {bus.req_ready, bus.alu_exec, bus.rsp_valid, bus.busy}, 4'b1000);
    end else begin
      k_cmp = cyc - m_tacc + 1;
      if (k_cmp <= m_n) begin
        chk("exec_ctl", {bus.req_ready, bus.alu_exec, bus.rsp_valid, bus.busy}, 4'b0101);
        chk("exec_ops", {bus.alu_opcode, bus.alu_a, bus.alu_b}, {m_op, m_a, m_b});
      end else begin
        chk("resp_ctl", {bus.req_ready, bus.alu_exec, bus.rsp_valid, bus.busy}, 4'b0011);
        chk("resp_data", {bus.rsp_lo, bus.rsp_hi, bus.rsp_err}, {m_lo, m_hi, m_err});
      end
    end
  end

  task automatic run_txn(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_err,
                         input int e_exec, input int e_lat);
    int lat;
    int nexec;
    @(posedge clock); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    bus.rsp_ready = 1'b0;
    chk({name, "_ready"}, bus.req_ready, 1'b1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    lat = 1; nexec = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.alu_exec) nexec++;
      @(posedge clock); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, e_lat);
    chk({name, "_nexec"}, nexec, e_exec);
    chk({name, "_rsp"}, {bus.rsp_lo, bus.rsp_hi, bus.rsp_err}, {e_lo, e_hi, e_err});
    // A competing request during the held response must be ignored.
    bus.req_valid = (hold > 0); bus.req_op = 4'd0; bus.req_a = 32'hFFFF; bus.req_b = 32'h1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk({name, "_hold"}, {bus.rsp_valid, bus.req_ready, bus.rsp_lo, bus.rsp_hi, bus.rsp_err},
          {2'b10, e_lo, e_hi, e_err});
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    chk({name, "_done"}, {bus.rsp_valid, bus.req_ready, bus.busy}, 3'b010);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } stim_t;

  stim_t stream[6];

  initial begin
    int idx;
    int guard;
    bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
    bus.rsp_ready = 1'b0;
    #2 clear_n = 1'b0;
    repeat (2) @(negedge clock);
    #1 clear_n = 1'b1;

    run_txn("add",   4'd0,  32'd5,          32'd7,          0, 32'd12, 32'd0, 1'b0, 1, 2);
    run_txn("mul",   4'd11, 32'h0001_0000,  32'h0001_0000,  0, 32'd0,  32'd1, 1'b0, 4, 5);
    run_txn("div",   4'd12, 32'd17,         32'd5,          3, 32'd3,  32'd2, 1'b0, 4, 5);
    run_txn("undefE",4'hE,  32'hCAFE_F00D,  32'h1234,       0, 32'd0,  32'd0, 1'b0, 0, 1);
    if (TRAP) run_txn("div0", 4'd12, 32'd9, 32'd0, 0, 32'd0, 32'd9, 1'b1, 0, 1);
    else      run_txn("div0", 4'd12, 32'd9, 32'd0, 0, 32'hFFFF_FFFF, 32'd9, 1'b0, 4, 5);
    run_txn("sub",   4'd1,  32'd10,         32'd3,          1, 32'd7,  32'd0, 1'b0, 1, 2);
    run_txn("undefF",4'hF,  32'd1,          32'd1,          0, 32'd0,  32'd0, 1'b0, 0, 1);
    run_txn("op10",  4'd10, 32'd1,          32'd2,          0, 32'd13, 32'd0, 1'b0, 1, 2);

    // Back-to-back stream with req_valid and rsp_ready held high.
    stream[0] = '{4'd0,  32'd3,   32'd4};
    stream[1] = '{4'd11, 32'd7,   32'd6};
    stream[2] = '{4'd0,  32'd100, 32'd200};
    stream[3] = '{4'd13, 32'd5,   32'd5};
    stream[4] = '{4'd12, 32'd100, 32'd7};
    stream[5] = '{4'd4,  32'hF0F0, 32'h0FF0};
    @(posedge clock); #1;
    bus.rsp_ready = 1'b1;
    idx = 0; guard = 0;
    bus.req_valid = 1'b1; bus.req_op = stream[0].op; bus.req_a = stream[0].a; bus.req_b = stream[0].b;
    while (idx < 6 && guard < 500) begin
      @(posedge clock); #1;
      guard++;
      if (acc_evt) begin
        idx++;
        if (idx < 6) begin
          bus.req_op = stream[idx].op; bus.req_a = stream[idx].a; bus.req_b = stream[idx].b;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    guard = 0;
    while (m_active && guard < 40) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("stream_drain", {m_active, bus.busy}, 2'b00);
    bus.rsp_ready = 1'b0;

    // Reset in the 2nd exec cycle of a MUL aborts it with no response.
    @(posedge clock); #1;
    bus.req_valid = 1'b1; bus.req_op = 4'd11; bus.req_a = 32'd2; bus.req_b = 32'd3;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    chk("abort_exec2", {bus.alu_exec, bus.busy}, 2'b11);
    #2 clear_n = 1'b0;
    #1;
    chk("abort_ctl", {bus.req_ready, bus.alu_exec, bus.rsp_valid, bus.busy}, 4'b1000);
    chk("abort_data", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_lo, bus.rsp_hi, bus.rsp_err}, '0);
    @(negedge clock); #1;
    clear_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chk("post_rst", {bus.busy, bus.rsp_valid, bus.alu_exec}, 3'b000);
    end
    bus.rsp_ready = 1'b0;
    run_txn("add2", 4'd0, 32'd20, 32'd22, 0, 32'd42, 32'd0, 1'b0, 1, 2);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/capture controller on the consumer side of the datapath ALU. Accepts one operation at a time over a valid/ready request channel and drives the ALU's opcode, exec and operand inputs for a programmable number of settle cycles. It then captures the LO result and HI word into output registers and presents them on a valid/ready response channel. It sits between the control unit and the ALU, replacing a fixed single-cycle exec pulse so that MUL/DIV get a longer settle window.

## Interface
- ALU_WAIT, 1: exec cycles for opcodes 0–10 (ADD..ROL); legal range ≥1.
- MULDIV_WAIT, 4: exec cycles for opcodes 11 (MUL) and 12 (DIV); legal range ≥1.
- clock  in  1  sole clock, rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  4  ALU opcode.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_opcode  out  4  registered opcode to ALU.
- alu_exec  out  1  ALU exec enable.
- alu_a  out  32  registered operand A to ALU.
- alu_b  out  32  registered operand B to ALU.
- alu_result  in  32  ALU LO result.
- alu_hi  in  32  ALU HI result.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes response.
- rsp_lo  out  32  captured LO.
- rsp_hi  out  32  captured HI.
- rsp_err  out  1  divide-by-zero trap flag.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: req_ready=1. When req_valid&req_ready at an edge, register req_op/req_a/req_b onto alu_opcode/alu_a/alu_b, load the down-counter with N-1, and go to EXEC.
  - N = MULDIV_WAIT for op 11/12; N = ALU_WAIT for op 0–10.
- Opcodes 13–15: no EXEC. Go directly to RESP with rsp_lo=0, rsp_hi=0, rsp_err=0.
- EXEC: alu_exec=1; operands and opcode held stable. The counter decrements each cycle. On the edge where the counter is 0:
  - rsp_lo ← alu_result.
  - rsp_hi ← alu_hi for op 11/12, else 0.
  - rsp_err ← 0.
  - State goes to RESP.
- RESP: rsp_valid=1 and rsp_lo/rsp_hi/rsp_err stable until the edge with rsp_ready=1. That edge returns the block to IDLE. alu_exec=0.
- req_valid is ignored outside IDLE. A request raised in RESP is accepted no earlier than the cycle after the response handshake.
- Counter width is $clog2(max(ALU_WAIT,MULDIV_WAIT))+1. No wrap: the counter only counts down from the loaded value.

## Timing
- Reset (clear_n=0, asynchronous): state=IDLE, counter=0.
  - alu_opcode=0, alu_a=0, alu_b=0, alu_exec=0.
  - rsp_valid=0, rsp_lo=0, rsp_hi=0, rsp_err=0, busy=0.
  - req_ready reads 1, but no request is accepted while clear_n=0.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. No response is ever produced for it.
- Accept at edge T. alu_exec is high for cycles T+1..T+N. rsp_valid rises in cycle T+N+1.
- Latency from accept to rsp_valid: N+1 cycles. Undefined opcode or trapped DIV: 1 cycle.
- Minimum issue interval: N+2 cycles, with rsp_ready held high.
- alu_exec, rsp_valid, busy and req_ready are decoded from state and carry no combinational path from inputs.

## Configuration
- ALU_SEQ_DIV0_TRAP_EN defined: op 12 with req_b==0 skips EXEC and goes to RESP at the next edge with rsp_lo=0, rsp_hi=req_a, rsp_err=1. alu_exec never asserts for that request.
- Not defined: DIV by zero executes normally for MULDIV_WAIT cycles and returns whatever the ALU produces. rsp_err is tied 0.

## Test plan
- ADD, A=5, B=7, ALU_WAIT=1, rsp_ready=1 -> alu_exec high exactly 1 cycle; rsp_valid 2 cycles after accept; rsp_lo=12, rsp_hi=0.
- MUL, A=0x00010000, B=0x00010000, MULDIV_WAIT=4 -> alu_exec high 4 cycles; rsp_lo=0, rsp_hi=1.
- DIV, A=17, B=5 with rsp_ready low for 3 cycles -> rsp_valid held with rsp_lo=3, rsp_hi=2 stable; req_ready=0 until the handshake edge.
- op=4'hE, any operands -> alu_exec never asserts; rsp_valid next cycle with rsp_lo=0, rsp_hi=0.
- DIV, A=9, B=0 with ALU_SEQ_DIV0_TRAP_EN defined -> rsp_err=1, rsp_hi=9, rsp_lo=0, alu_exec never high. Without the macro -> rsp_err=0 and 4 exec cycles.
- clear_n pulled low in the 2nd EXEC cycle of a MUL -> all outputs 0 immediately; after release, busy=0, no rsp_valid, and the next ADD completes normally.
